// File: rtl/calc_key_sequencer_if.sv
// calc_key_sequencer_if
// Key-entry handshake plus the command strobe bus that the key sequencer
// drives into the operand/operator storage stage.
//   key_valid / key_code / key_ready : debounced key handshake (consumed on valid & ready)
//   num, operator                    : digit value and operator select
//   save_enable, op_enable           : storage target select (00 none, 01 A/result, 10 op, 11 B)
//   equ_enable, clear_enable         : load result into A / clear all storage
//   disp_sel, err                    : display operand select, rejected-key pulse
// master = key source / observer side, slave = sequencer side.
interface calc_key_sequencer_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] num;
  logic [1:0] operator;
  logic [1:0] save_enable;
  logic       op_enable;
  logic       equ_enable;
  logic       clear_enable;
  logic       disp_sel;
  logic       err;

  modport master (
    output key_valid, key_code,
    input  key_ready, num, operator, save_enable, op_enable,
           equ_enable, clear_enable, disp_sel, err
  );

  modport slave (
    input  key_valid, key_code,
    output key_ready, num, operator, save_enable, op_enable,
           equ_enable, clear_enable, disp_sel, err
  );
endinterface

// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer
// Keypad-entry controller: turns debounced key codes into single-cycle
// command strobes for the calculator operand/operator storage stage.
// Tracks digit counts per operand, enforces MAX_DIGITS, and splits a digit
// typed over a shown result into a clear followed by the digit save.
// Ports:
//   clk  : system clock, posedge
//   rst  : synchronous active-high reset
//   kif  : calc_key_sequencer_if.slave (key handshake in, command strobes out)
// Parameter:
//   MAX_DIGITS : digits accepted per operand (1..4)
module calc_key_sequencer #(
  parameter int MAX_DIGITS = 4
) (
  input logic                   clk,
  input logic                   rst,
  calc_key_sequencer_if.slave   kif
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_RES  = 2'd2,
    S_PEND = 2'd3
  } state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  state_t     state, state_n;
  logic [2:0] cnt_a, cnt_a_n;
  logic [2:0] cnt_b, cnt_b_n;
  logic [3:0] pend_digit, pend_digit_n;

  logic [3:0] num_q, num_n;
  logic [1:0] operator_q, operator_n;
  logic [1:0] save_q, save_n;
  logic       op_en_q, op_en_n;
  logic       equ_en_q, equ_en_n;
  logic       clr_en_q, clr_en_n;
  logic       disp_q, disp_n;
  logic       err_q, err_n;

  logic       key_take;
  logic       is_digit, is_op, is_equ, is_clr;
  logic [1:0] op_sel;

  // Key decode. Codes 0xA..0xD map to 00..11; adding 2 to the low two bits
  // of the code yields exactly code-0xA for that range.
  always_comb begin
    is_digit = (kif.key_code <= 4'd9);
    is_op    = (kif.key_code >= 4'hA) && (kif.key_code <= 4'hD);
    is_equ   = (kif.key_code == 4'hE);
    is_clr   = (kif.key_code == 4'hF);
    op_sel   = kif.key_code[1:0] + 2'd2;
  end

  // The only stall is the single S_PEND cycle where the latched digit is saved.
  assign key_take = kif.key_valid && (state != S_PEND);

  always_comb begin
    state_n      = state;
    cnt_a_n      = cnt_a;
    cnt_b_n      = cnt_b;
    pend_digit_n = pend_digit;
    num_n        = num_q;
    operator_n   = operator_q;
    save_n       = 2'b00;
    op_en_n      = 1'b0;
    equ_en_n     = 1'b0;
    clr_en_n     = 1'b0;
    err_n        = 1'b0;

    if (state == S_PEND) begin
      save_n  = 2'b01;
      num_n   = pend_digit;
      cnt_a_n = 3'd1;
      cnt_b_n = 3'd0;
      state_n = S_A;
    end else if (key_take) begin
      if (is_clr) begin
        clr_en_n = 1'b1;
        cnt_a_n  = 3'd0;
        cnt_b_n  = 3'd0;
        state_n  = S_A;
      end else begin
        unique case (state)
          S_A: begin
            if (is_digit) begin
              if (cnt_a < MAX_CNT) begin
                save_n  = 2'b01;
                num_n   = kif.key_code;
                cnt_a_n = cnt_a + 3'd1;
              end else begin
                err_n = 1'b1;
              end
            end else if (is_op) begin
              save_n     = 2'b10;
              op_en_n    = 1'b1;
              operator_n = op_sel;
              cnt_b_n    = 3'd0;
              state_n    = S_B;
            end else begin
              err_n = 1'b1;
            end
          end
          S_B: begin
            if (is_digit) begin
              if (cnt_b < MAX_CNT) begin
                save_n  = 2'b11;
                num_n   = kif.key_code;
                cnt_b_n = cnt_b + 3'd1;
              end else begin
                err_n = 1'b1;
              end
            end else if (is_op) begin
              // Operator may only be changed before any B digit is entered.
              if (cnt_b == 3'd0) begin
                save_n     = 2'b10;
                op_en_n    = 1'b1;
                operator_n = op_sel;
              end else begin
                err_n = 1'b1;
              end
            end else if (is_equ && (cnt_b != 3'd0)) begin
              save_n   = 2'b01;
              equ_en_n = 1'b1;
              cnt_a_n  = MAX_CNT;
              state_n  = S_RES;
            end else begin
              err_n = 1'b1;
            end
          end
          S_RES: begin
            // A digit over a shown result starts a fresh entry: clear now,
            // save the digit from S_PEND on the following cycle.
            if (is_digit) begin
              clr_en_n     = 1'b1;
              pend_digit_n = kif.key_code;
              state_n      = S_PEND;
            end else begin
              err_n = 1'b1;
            end
          end
          default: begin
            state_n = S_A;
          end
        endcase
      end
    end

    disp_n = (state_n == S_B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_A;
      cnt_a      <= 3'd0;
      cnt_b      <= 3'd0;
      num_q      <= 4'd0;
      operator_q <= 2'b00;
      save_q     <= 2'b00;
      op_en_q    <= 1'b0;
      equ_en_q   <= 1'b0;
      clr_en_q   <= 1'b0;
      disp_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt_a      <= cnt_a_n;
      cnt_b      <= cnt_b_n;
      num_q      <= num_n;
      operator_q <= operator_n;
      save_q     <= save_n;
      op_en_q    <= op_en_n;
      equ_en_q   <= equ_en_n;
      clr_en_q   <= clr_en_n;
      disp_q     <= disp_n;
      err_q      <= err_n;
    end
  end

  // Pending digit is pure data; it is only read in S_PEND, which reset leaves.
  always_ff @(posedge clk) begin
    pend_digit <= pend_digit_n;
  end

  assign kif.key_ready    = (state != S_PEND);
  assign kif.num          = num_q;
  assign kif.operator     = operator_q;
  assign kif.save_enable  = save_q;
  assign kif.op_enable    = op_en_q;
  assign kif.equ_enable   = equ_en_q;
  assign kif.clear_enable = clr_en_q;
  assign kif.disp_sel     = disp_q;
  assign kif.err          = err_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb_calc_key_sequencer
// Table-driven directed vectors, hand sequences for the post-result clear
// and reset during the pending cycle, then random keys against a flag-based
// reference model of the entry rules.
module tb_calc_key_sequencer;
  localparam int MAXD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calc_key_sequencer_if kif ();

  calc_key_sequencer #(.MAX_DIGITS(MAXD)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  typedef struct packed {
    logic       ready;
    logic [3:0] num;
    logic [1:0] op;
    logic [1:0] save;
    logic       op_en;
    logic       equ;
    logic       clr;
    logic       disp;
    logic       err;
  } obs_t;

  typedef struct {
    logic       v;
    logic [3:0] c;
    obs_t       e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic obs_t mk(input logic ready, input int num, input int op,
                              input int save, input logic op_en, input logic equ,
                              input logic clr, input logic disp, input logic err);
    obs_t o;
    o.ready = ready;
    o.num   = 4'(num);
    o.op    = 2'(op);
    o.save  = 2'(save);
    o.op_en = op_en;
    o.equ   = equ;
    o.clr   = clr;
    o.disp  = disp;
    o.err   = err;
    return o;
  endfunction

  function automatic obs_t actual();
    obs_t o;
    o.ready = kif.key_ready;
    o.num   = kif.num;
    o.op    = kif.operator;
    o.save  = kif.save_enable;
    o.op_en = kif.op_enable;
    o.equ   = kif.equ_enable;
    o.clr   = kif.clear_enable;
    o.disp  = kif.disp_sel;
    o.err   = kif.err;
    return o;
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t a;
    a = actual();
    n_checks++;
    if (a !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b num=%h op=%b save=%b ope=%b equ=%b clr=%b disp=%b err=%b, expected rdy=%b num=%h op=%b save=%b ope=%b equ=%b clr=%b disp=%b err=%b",
               name, a.ready, a.num, a.op, a.save, a.op_en, a.equ, a.clr, a.disp, a.err,
               exp.ready, exp.num, exp.op, exp.save, exp.op_en, exp.equ, exp.clr, exp.disp, exp.err);
    end
  endtask

  // Reference model: entry phase as flags plus digit counts.
  bit         m_in_b, m_res, m_pend_v;
  int         m_na, m_nb;
  logic [3:0] m_pend;
  obs_t       m_exp;

  task automatic model(input logic r, input logic v, input logic [3:0] c);
    obs_t e;
    e = m_exp;
    e.save = 2'b00; e.op_en = 1'b0; e.equ = 1'b0; e.clr = 1'b0; e.err = 1'b0;
    if (r) begin
      m_in_b = 0; m_res = 0; m_pend_v = 0; m_na = 0; m_nb = 0;
      e.num = 4'd0; e.op = 2'd0;
    end else if (m_pend_v) begin
      e.save = 2'b01; e.num = m_pend; m_na = 1; m_nb = 0; m_pend_v = 0;
    end else if (v) begin
      if (c == 4'hF) begin
        e.clr = 1'b1; m_in_b = 0; m_res = 0; m_na = 0; m_nb = 0;
      end else if (c <= 4'd9) begin
        if (m_res) begin
          e.clr = 1'b1; m_pend = c; m_pend_v = 1; m_res = 0;
        end else if (m_in_b) begin
          if (m_nb < MAXD) begin e.save = 2'b11; e.num = c; m_nb++; end
          else e.err = 1'b1;
        end else begin
          if (m_na < MAXD) begin e.save = 2'b01; e.num = c; m_na++; end
          else e.err = 1'b1;
        end
      end else if (c <= 4'hD) begin
        if (m_res || (m_in_b && m_nb > 0)) e.err = 1'b1;
        else begin
          e.save = 2'b10; e.op_en = 1'b1; e.op = 2'(int'(c) - 10);
          m_in_b = 1; m_nb = 0;
        end
      end else begin
        if (m_in_b && m_nb > 0) begin
          e.save = 2'b01; e.equ = 1'b1; m_na = MAXD; m_in_b = 0; m_res = 1;
        end else e.err = 1'b1;
      end
    end
    e.disp  = m_in_b;
    e.ready = !m_pend_v;
    m_exp   = e;
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] c);
    rst           = r;
    kif.key_valid = v;
    kif.key_code  = c;
    @(posedge clk);
    model(r, v, c);
    #1;
  endtask

  vec_t tbl[$];

  function automatic vec_t vec(input logic v, input int c, input obs_t e);
    vec_t t;
    t.v = v;
    t.c = 4'(c);
    t.e = e;
    return t;
  endfunction

  initial begin
    rst = 1'b1;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'd0;
    m_exp = '0;

    //                       rdy num op sv ope equ clr dsp err
    tbl.push_back(vec(1, 1,  mk(1, 1, 0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(vec(1, 2,  mk(1, 2, 0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(vec(1, 10, mk(1, 2, 0, 2, 1, 0, 0, 1, 0)));
    tbl.push_back(vec(1, 3,  mk(1, 3, 0, 3, 0, 0, 0, 1, 0)));
    tbl.push_back(vec(1, 14, mk(1, 3, 0, 1, 0, 1, 0, 0, 0)));
    tbl.push_back(vec(1, 7,  mk(0, 3, 0, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(vec(1, 8,  mk(1, 7, 0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(vec(1, 8,  mk(1, 8, 0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(vec(1, 3,  mk(1, 3, 0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(vec(1, 4,  mk(1, 4, 0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(vec(1, 5,  mk(1, 4, 0, 0, 0, 0, 0, 0, 1)));
    tbl.push_back(vec(0, 0,  mk(1, 4, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(vec(1, 11, mk(1, 4, 1, 2, 1, 0, 0, 1, 0)));
    tbl.push_back(vec(1, 12, mk(1, 4, 2, 2, 1, 0, 0, 1, 0)));
    tbl.push_back(vec(1, 14, mk(1, 4, 2, 0, 0, 0, 0, 1, 1)));
    tbl.push_back(vec(1, 5,  mk(1, 5, 2, 3, 0, 0, 0, 1, 0)));
    tbl.push_back(vec(1, 13, mk(1, 5, 2, 0, 0, 0, 0, 1, 1)));
    tbl.push_back(vec(1, 15, mk(1, 5, 2, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(vec(1, 14, mk(1, 5, 2, 0, 0, 0, 0, 0, 1)));
    tbl.push_back(vec(1, 6,  mk(1, 6, 2, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(vec(1, 7,  mk(1, 7, 2, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(vec(1, 8,  mk(1, 8, 2, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(vec(1, 9,  mk(1, 9, 2, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(vec(1, 0,  mk(1, 9, 2, 0, 0, 0, 0, 0, 1)));

    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd5);
    check("reset", mk(1, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].v, tbl[i].c);
      check($sformatf("vec%0d_key%h", i, tbl[i].c), tbl[i].e);
    end

    // Reset while the post-result digit is pending: digit must be dropped.
    step(1'b0, 1'b1, 4'hF);
    step(1'b0, 1'b1, 4'd1);
    step(1'b0, 1'b1, 4'hA);
    step(1'b0, 1'b1, 4'd2);
    step(1'b0, 1'b1, 4'hE);
    check("result_equ", mk(1, 2, 0, 1, 0, 1, 0, 0, 0));
    step(1'b0, 1'b1, 4'd9);
    check("pend_clear", mk(0, 2, 0, 0, 0, 0, 1, 0, 0));
    step(1'b1, 1'b1, 4'd5);
    check("rst_in_pend", mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b0, 4'd0);
    check("after_rst_pend", mk(1, 0, 0, 0, 0, 0, 0, 0, 0));

    // Random keys against the reference model.
    for (int k = 0; k < 800; k++) begin
      logic r, v;
      logic [3:0] c;
      r = ($urandom_range(0, 63) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = 4'($urandom_range(0, 15));
      step(r, v, c);
      check($sformatf("rand%0d", k), m_exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
